k16_bus_decoder: RTL

- Sits directly downstream of the K16Cpu memory bus (address, data_out, write in; data_in out). Splits each access across three targets:
  - program RAM
  - text framebuffer RAM
  - an on-block I/O register file (front-panel switches/LEDs, 32-bit cycle counter)
- Returns read data with the same one-cycle registered latency the CPU already expects from plain RAM.

---
 rtl/k16_bus_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/k16_bus_decoder.sv
// K16 memory-bus decoder: splits CPU accesses between program RAM, the text
// framebuffer and a small I/O register file, returning read data one cycle later.
module k16_bus_decoder #(
  parameter int unsigned RAM_ADDR_BITS = 14,
  parameter logic [15:0] FB_BASE       = 16'h8000,
  parameter int unsigned FB_ADDR_BITS  = 11,
  parameter logic [15:0] IO_BASE       = 16'hFFF8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              address,
  input  logic [15:0]              data_out,
  input  logic                     write,
  output logic [15:0]              data_in,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [15:0]              ram_wdata,
  output logic                     ram_write,
  input  logic [15:0]              ram_rdata,
  output logic [FB_ADDR_BITS-1:0]  fb_address,
  output logic [15:0]              fb_wdata,
  output logic                     fb_write,
  input  logic [15:0]              fb_rdata,
  input  logic [15:0]              addr_switches,
  input  logic [15:0]              ctrl_switches,
  input  logic [15:0]              reg_switches,
  output logic [15:0]              addr_leds,
  output logic [15:0]              data_leds
);

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_RAM  = 2'd1,
    RGN_FB   = 2'd2,
    RGN_IO   = 2'd3
  } region_e;

  localparam logic [2:0] IO_ADDR_SW = 3'd0;
  localparam logic [2:0] IO_CTRL_SW = 3'd1;
  localparam logic [2:0] IO_REG_SW  = 3'd2;
  localparam logic [2:0] IO_ADDR_LD = 3'd3;
  localparam logic [2:0] IO_DATA_LD = 3'd4;
  localparam logic [2:0] IO_CNTR_LO = 3'd5;
  localparam logic [2:0] IO_CNTR_HI = 3'd6;

  // 17-bit bounds so a region that reaches 16'hFFFF still compares correctly.
  localparam logic [16:0] RAM_END = 17'd1 << RAM_ADDR_BITS;
  localparam logic [16:0] FB_LO   = {1'b0, FB_BASE};
  localparam logic [16:0] FB_END  = FB_LO + (17'd1 << FB_ADDR_BITS);

  logic [16:0] addr_ext;
  logic        ram_hit;
  logic        fb_hit;
  logic        io_hit;
  logic [2:0]  io_off;
  region_e     region_sel;

  region_e     region_q, region_d;
  logic [15:0] io_rdata_q, io_rdata_d;
  logic [15:0] addr_leds_q, addr_leds_d;
  logic [15:0] data_leds_q, data_leds_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] hi_latch_q, hi_latch_d;
  logic [15:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
  logic [15:0] ctrl_s1_q, ctrl_s1_d, ctrl_s2_q, ctrl_s2_d;
  logic [15:0] reg_s1_q, reg_s1_d, reg_s2_q, reg_s2_d;

  // Regions are base-aligned, so the low address bits are the region offset.
  always_comb begin
    addr_ext = {1'b0, address};
    ram_hit  = addr_ext < RAM_END;
    fb_hit   = !ram_hit && (addr_ext >= FB_LO) && (addr_ext < FB_END);
    io_hit   = !ram_hit && !fb_hit && (address >= IO_BASE);
    io_off   = address[2:0];
    region_sel = RGN_NONE;
    if (ram_hit)     region_sel = RGN_RAM;
    else if (fb_hit) region_sel = RGN_FB;
    else if (io_hit) region_sel = RGN_IO;
  end

  assign ram_address = address[RAM_ADDR_BITS-1:0];
  assign fb_address  = address[FB_ADDR_BITS-1:0];
  assign ram_wdata   = data_out;
  assign fb_wdata    = data_out;
  assign ram_write   = write && ram_hit && !reset;
  assign fb_write    = write && fb_hit && !reset;
  assign addr_leds   = addr_leds_q;
  assign data_leds   = data_leds_q;

  always_comb begin
    region_d    = region_sel;
    addr_s1_d   = addr_switches;
    addr_s2_d   = addr_s1_q;
    ctrl_s1_d   = ctrl_switches;
    ctrl_s2_d   = ctrl_s1_q;
    reg_s1_d    = reg_switches;
    reg_s2_d    = reg_s1_q;
    addr_leds_d = addr_leds_q;
    data_leds_d = data_leds_q;
    cnt_d       = cnt_q + 32'd1;
    hi_latch_d  = hi_latch_q;
    io_rdata_d  = 16'h0000;

    case (io_off)
      IO_ADDR_SW: io_rdata_d = addr_s2_q;
      IO_CTRL_SW: io_rdata_d = ctrl_s2_q;
      IO_REG_SW:  io_rdata_d = reg_s2_q;
      IO_ADDR_LD: io_rdata_d = addr_leds_q;
      IO_DATA_LD: io_rdata_d = data_leds_q;
      IO_CNTR_LO: io_rdata_d = cnt_q[15:0];
      IO_CNTR_HI: io_rdata_d = hi_latch_q;
      default:    io_rdata_d = 16'h0000;
    endcase

    if (io_hit && write) begin
      case (io_off)
        IO_ADDR_LD: addr_leds_d = data_out;
        IO_DATA_LD: data_leds_d = data_out;
        IO_CNTR_LO: cnt_d       = 32'd0;
        default:    ;
      endcase
    end

    // Freezing the upper half on every low read keeps a lo-then-hi pair coherent.
    if (io_hit && !write && io_off == IO_CNTR_LO) hi_latch_d = cnt_q[31:16];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q    <= RGN_NONE;
      io_rdata_q  <= 16'h0000;
      addr_leds_q <= 16'h0000;
      data_leds_q <= 16'h0000;
      cnt_q       <= 32'd0;
      hi_latch_q  <= 16'h0000;
      addr_s1_q   <= 16'h0000;
      addr_s2_q   <= 16'h0000;
      ctrl_s1_q   <= 16'h0000;
      ctrl_s2_q   <= 16'h0000;
      reg_s1_q    <= 16'h0000;
      reg_s2_q    <= 16'h0000;
    end else begin
      region_q    <= region_d;
      io_rdata_q  <= io_rdata_d;
      addr_leds_q <= addr_leds_d;
      data_leds_q <= data_leds_d;
      cnt_q       <= cnt_d;
      hi_latch_q  <= hi_latch_d;
      addr_s1_q   <= addr_s1_d;
      addr_s2_q   <= addr_s2_d;
      ctrl_s1_q   <= ctrl_s1_d;
      ctrl_s2_q   <= ctrl_s2_d;
      reg_s1_q    <= reg_s1_d;
      reg_s2_q    <= reg_s2_d;
    end
  end

  always_comb begin
    data_in = 16'h0000;
    case (region_q)
      RGN_RAM: data_in = ram_rdata;
      RGN_FB:  data_in = fb_rdata;
      RGN_IO:  data_in = io_rdata_q;
      default: data_in = 16'h0000;
    endcase
  end

endmodule
